// File: rtl/alu_logic_collect.sv
// Result-collection stage behind the adiabatic logic arrays: launches operands,
// tracks them through the fixed-latency pipeline and buffers results for writeback.
module alu_logic_collect #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clkpos,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [WIDTH-1:0]           logic_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       res_zero,
    output logic [$clog2(DEPTH+1)-1:0] res_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and issue_ready comes from
    // registers only, so neither res_ready nor issue_valid reaches it.

    logic [LAT-1:0]   vld_pipe;
    logic [CW-1:0]    pending;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic capture;
    logic pop;

    assign issue_ready = (pending < CW'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign capture     = vld_pipe[LAT-1];
    assign res_valid   = (count != '0);
    assign pop         = res_valid && res_ready;
    assign res_data    = res_valid ? mem[rd_ptr] : '0;
    assign res_zero    = res_valid && (res_data == '0);
    assign res_count   = count;

    // The logic array cannot stall, so only launch validity is tracked here.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // Credits cover in-flight plus buffered results, which keeps the FIFO from overflowing.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (capture) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clkpos) begin
        if (capture) begin
            mem[wr_ptr] <= logic_out;
        end
    end

endmodule

// File: tb/tb_alu_logic_collect.sv
// Directed bench for alu_logic_collect with a modelled OR array feeding logic_out
// and a queue of expected results checked at every pop.
module tb_alu_logic_collect;
    localparam int WIDTH = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clkpos = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] logic_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [CW-1:0]    res_count;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    int checks = 0;
    int errors = 0;
    int n_accept = 0;
    int n_pop = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clkpos = ~clkpos;

    alu_logic_collect #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clkpos      (clkpos),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .logic_out   (logic_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_count   (res_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clkpos);
        #1;
    endtask

    // OR-array model: a launch appears on logic_out LAT edges later; junk otherwise.
    logic             launch_q = 1'b0;
    logic [WIDTH-1:0] launch_val = '0;
    logic [LAT-1:0]   arr_v = '0;
    logic [WIDTH-1:0] arr_d [LAT];
    logic [WIDTH-1:0] junk = '0;

    initial begin
        for (int i = 0; i < LAT; i++) arr_d[i] = '0;
    end

    assign logic_out = arr_v[LAT-1] ? arr_d[LAT-1] : junk;

    always @(posedge clkpos) begin
        arr_v[0] <= launch_q;
        arr_d[0] <= launch_val;
        for (int i = 1; i < LAT; i++) begin
            arr_v[i] <= arr_v[i-1];
            arr_d[i] <= arr_d[i-1];
        end
        junk <= WIDTH'($urandom);
    end

    // Scoreboard: decides at the negedge what the next rising edge will do.
    always @(negedge clkpos) begin
        logic [WIDTH-1:0] e;
        launch_q = 1'b0;
        if (!rst) begin
            if (arr_v[LAT-1]) begin
                check("cap_not_full", 32'(res_count != CW'(DEPTH)), 32'd1);
            end
            if (issue_valid && issue_ready) begin
                launch_q   = 1'b1;
                launch_val = op_a | op_b;
                exp_q.push_back(op_a | op_b);
                n_accept++;
            end
            if (res_valid && res_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("pop_has_expected", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e));
                    check("res_zero", 32'(res_zero), 32'(e == '0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na0;
        int np0;
        rst = 1'b1;
        issue_valid = 1'b0;
        res_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        #2;
        step(2);
        rst = 1'b0;
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_zero", 32'(res_zero), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);

        // Single op: accepted at edge 1, captured at edge 3.
        op_a = 16'h00F0;
        op_b = 16'h0F00;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        check("single_e1_valid", 32'(res_valid), 32'd0);
        step();
        check("single_e2_valid", 32'(res_valid), 32'd0);
        step();
        check("single_e3_valid", 32'(res_valid), 32'd1);
        check("single_e3_data", 32'(res_data), 32'h0FF0);
        check("single_e3_zero", 32'(res_zero), 32'd0);
        check("single_e3_count", 32'(res_count), 32'd1);
        res_ready = 1'b1;
        step();
        check("single_pop_valid", 32'(res_valid), 32'd0);
        check("single_pop_count", 32'(res_count), 32'd0);
        res_ready = 1'b0;

        // Zero result.
        op_a = 16'h0000;
        op_b = 16'h0000;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step(2);
        check("zero_valid", 32'(res_valid), 32'd1);
        check("zero_data", 32'(res_data), 32'd0);
        check("zero_flag", 32'(res_zero), 32'd1);
        res_ready = 1'b1;
        step();
        check("zero_flag_drop", 32'(res_zero), 32'd0);
        check("zero_valid_drop", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Backpressure: only DEPTH launches accepted while the consumer stalls.
        na0 = n_accept;
        issue_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op_a = WIDTH'(16'h0101 * (i + 1));
            op_b = WIDTH'(i << 12);
            step();
            if (i >= 3) check("bp_ready_low", 32'(issue_ready), 32'd0);
        end
        issue_valid = 1'b0;
        check("bp_accepts", 32'(n_accept - na0), 32'd4);
        check("bp_count_full", 32'(res_count), 32'd4);
        res_ready = 1'b1;
        step();
        check("bp_ready_after_pop", 32'(issue_ready), 32'd1);
        step(3);
        check("bp_drained_count", 32'(res_count), 32'd0);
        check("bp_drained_valid", 32'(res_valid), 32'd0);

        // Streaming: one issue per cycle, capture and pop together at count 1.
        np0 = n_pop;
        res_ready = 1'b1;
        issue_valid = 1'b1;
        op_a = 16'h0001;
        op_b = 16'h0000;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e <= 16) check("stream_ready", 32'(issue_ready), 32'd1);
            if (e >= 3 && e <= 18) begin
                check("stream_valid", 32'(res_valid), 32'd1);
                check("stream_count", 32'(res_count), 32'd1);
            end
            if (e >= 19) check("stream_idle", 32'(res_valid), 32'd0);
            if (e < 16) begin
                op_a = WIDTH'(1) << e;
                op_b = (e % 2 == 1) ? (WIDTH'(1) << e) : WIDTH'(0);
            end else begin
                issue_valid = 1'b0;
            end
        end
        check("stream_pops", 32'(n_pop - np0), 32'd16);

        // Mid-flight reset: two buffered, two in flight.
        res_ready = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a = (i == 0) ? WIDTH'(0) : WIDTH'(16'hA000 | i);
            op_b = (i == 0) ? WIDTH'(0) : WIDTH'(16'h0050);
            step();
        end
        issue_valid = 1'b0;
        check("mid_count_before", 32'(res_count), 32'd2);
        check("mid_zero_before", 32'(res_zero), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_count", 32'(res_count), 32'd0);
        check("mid_rst_zero", 32'(res_zero), 32'd0);
        check("mid_rst_data", 32'(res_data), 32'd0);
        check("mid_rst_ready", 32'(issue_ready), 32'd1);
        exp_q.delete();
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_quiet", 32'(res_valid), 32'd0);
        end

        // Normal operation resumes after reset.
        op_a = 16'h1234;
        op_b = 16'h4321;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step(2);
        check("resume_valid", 32'(res_valid), 32'd1);
        check("resume_data", 32'(res_data), 32'h5335);
        step();
        check("resume_drained", 32'(res_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_logic_collect.md
Name: alu_logic_collect

Overview:
- Result-collection stage directly downstream of the 16-bit OR array and its sibling logic arrays in the adiabatic ALU datapath.
- Issues operand launches, tracks them through the fixed-latency adiabatic logic pipeline, and captures the logic result when it emerges.
- Buffers captured results in a small FIFO and presents them to the writeback/consumer with a valid/ready handshake and a zero flag.
- The logic pipeline cannot stall, so backpressure is applied at issue through credit accounting.

Parameters:
- WIDTH, 16, result width; matches the logic array output.
- LAT, 2, clock edges from issue acceptance to valid data on logic_out (≥1).
- DEPTH, 4, result FIFO entries; power of two, ≥ LAT+1 for full throughput.

Ports:
- clkpos  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  upstream requests to launch an operand pair into the logic array.
- issue_ready  output  1  a launch is accepted this cycle.
- logic_out  input  WIDTH  result bus from the logic array (the OR array's out).
- res_valid  output  1  res_data holds a buffered result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  oldest buffered result.
- res_zero  output  1  res_valid and (res_data == 0).
- res_count  output  $clog2(DEPTH+1)  FIFO occupancy.

Interface decision: one clock; reset is asynchronous and active-high (clkpos, rst).

Behaviour:
- Reset (async assert, sync release), effective immediately on assertion:
  - vld_pipe, FIFO pointers, count and the pending counter all cleared.
  - Outputs: issue_ready=1, res_valid=0, res_data=0, res_zero=0, res_count=0.
  - FIFO storage is not reset.
- Accept: issue_valid && issue_ready at edge k.
- Valid tracking: shift register vld_pipe[LAT-1:0].
  - vld_pipe[0] <= accept; each stage shifts by one per edge.
  - logic_out is captured into the FIFO at edge k+LAT, i.e. whenever vld_pipe[LAT-1]=1 at that edge.
  - logic_out is ignored in all other cycles.
- Credit: a registered counter pending = in-flight + buffered.
  - +1 on accept, −1 on pop; both in the same cycle leaves it unchanged.
  - issue_ready = (pending < DEPTH), derived from registers only, with no combinational path from res_ready or issue_valid.
  - issue_valid while issue_ready=0 is ignored; no state change.
- FIFO is first-word-fall-through.
  - res_valid = (count != 0).
  - res_data = mem[rd_ptr] when valid, else 0.
  - Pop on res_valid && res_ready.
  - Pointers wrap modulo DEPTH.
- Latency: a result captured at edge k+LAT is visible after that edge. There is no same-cycle bypass when the FIFO is empty, so issue in cycle k gives res_valid in cycle k+LAT+1 at the earliest.
- Simultaneous capture and pop: count unchanged; order preserved.
- Overflow is impossible by construction, since count + in-flight ≤ DEPTH always holds. The bench asserts no capture ever occurs with count==DEPTH.
- Data passes through unmodified; no arithmetic on the datapath.
- Reset mid-operation discards both in-flight and buffered results. Later logic_out activity produces no output until new launches are accepted.
- Full-throughput streaming (res_ready held 1) sustains one issue per cycle when DEPTH ≥ LAT+1.

Test Plan:
- Single op, LAT=2/DEPTH=4: a=0x00F0, b=0x0F00 accepted at edge 1 → logic_out 0x0FF0 captured at edge 3; after edge 3 res_valid=1, res_data=0x0FF0, res_zero=0, res_count=1.
- Zero result: a=b=0x0000 → res_data=0x0000, res_zero=1; both drop to 0 the cycle after the pop.
- Backpressure: res_ready=0, issue_valid=1 continuously.
  - Exactly 4 accepts; issue_ready=0 after the 4th accept edge; res_count reaches 4.
  - Raising res_ready drains the 4 results in issue order.
  - issue_ready returns to 1 the cycle after the first pop.
- Streaming: res_ready=1, 16 back-to-back issues with operands giving 0x0001<<i → 16 results in order, one per cycle from cycle LAT+2 on; issue_ready never drops.
- Simultaneous capture and pop at count=1 → res_count stays 1 and output order is unchanged.
- Mid-flight reset: 2 in-flight plus 2 buffered, rst asserted between edges.
  - Immediately: res_valid=0, res_count=0, res_zero=0, issue_ready=1.
  - After release, logic_out toggling with no issues produces no res_valid for 10 cycles.
